// File: rtl/alu_pkg.sv
// Shared widths and the tagged result record used by the ALU result collector and its FIFO.
package alu_pkg;

    localparam int ALU_WORD_W = 16;
    localparam int ALU_N_SRC  = 8;
    localparam int ALU_SRC_W  = $clog2(ALU_N_SRC);

    typedef struct packed {
        logic [ALU_WORD_W-1:0] data;
        logic [ALU_SRC_W-1:0]  src;
        logic                  zero;
    } alu_result_t;

endpackage

// File: rtl/alu_result_fifo2.sv
// Two-entry FIFO of tagged ALU results with registered count-based valid/ready.
module alu_result_fifo2
    import alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_push,
    input  alu_result_t i_wdata,
    output logic        o_in_ready,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output alu_result_t o_rdata
);

    alu_result_t r_mem [2];
    logic        r_wr_ptr;
    logic        r_rd_ptr;
    logic [1:0]  r_count;

    logic w_push;
    logic w_pop;

    assign o_in_ready  = (r_count != 2'd2);
    assign o_out_valid = (r_count != 2'd0);

    // Guarded again here so a misbehaving producer can never overwrite an unread entry.
    assign w_push = i_push && o_in_ready;
    assign w_pop  = o_out_valid && i_out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Storage is not reset, so an empty FIFO presents an all-zero head instead of stale data.
    assign o_rdata = o_out_valid ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/alu_result_collector.sv
// Collects AND-gated ALU result lanes into one tagged word per handshake and queues it for writeback.
// Optional macro ALU_COLLECTOR_SEL_CHECK_EN drops transfers whose sel is not one-hot and counts them.
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WORD_W,
    parameter int N_SRC = ALU_N_SRC
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [N_SRC*WIDTH-1:0]   lanes,
    input  logic [N_SRC-1:0]         sel,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [$clog2(N_SRC)-1:0] out_src,
    output logic                     out_zero,
    output logic                     sel_err,
    output logic [7:0]               err_count
);

    localparam int SRC_W = $clog2(N_SRC);

    function automatic logic [SRC_W-1:0] f_low_idx(input logic [N_SRC-1:0] s);
        logic [SRC_W-1:0] idx;
        idx = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (s[i]) begin
                idx = i[SRC_W-1:0];
            end
        end
        return idx;
    endfunction

    logic [WIDTH-1:0] w_word_p0;
    alu_result_t      w_entry_p0;
    alu_result_t      w_head;
    logic             w_accept;
    logic             w_push;

    assign w_accept = in_valid && in_ready;

    // Lanes are already gated upstream, so a plain OR merges them.
    always_comb begin
        w_word_p0 = '0;
        for (int i = 0; i < N_SRC; i++) begin
            w_word_p0 = w_word_p0 | lanes[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        w_entry_p0      = '0;
        w_entry_p0.data = w_word_p0;
        w_entry_p0.src  = f_low_idx(sel);
        w_entry_p0.zero = ~|w_word_p0;
    end

`ifdef ALU_COLLECTOR_SEL_CHECK_EN
    function automatic logic [7:0] f_sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    logic       w_bad_p0;
    logic       r_sel_err_p1;
    logic [7:0] r_err_count_p1;

    // A rejected transfer still completes its handshake; it is simply not queued.
    assign w_bad_p0 = w_accept && !$onehot(sel);
    assign w_push   = w_accept && !w_bad_p0;

    // ---- capture -> error report boundary ----
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sel_err_p1   <= 1'b0;
            r_err_count_p1 <= 8'd0;
        end else begin
            r_sel_err_p1 <= w_bad_p0;
            if (w_bad_p0) begin
                r_err_count_p1 <= f_sat_inc(r_err_count_p1);
            end
        end
    end

    assign sel_err   = r_sel_err_p1;
    assign err_count = r_err_count_p1;
`else
    assign w_push    = w_accept;
    assign sel_err   = 1'b0;
    assign err_count = 8'd0;
`endif

    // ---- capture -> FIFO boundary ----
    alu_result_fifo2 u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_wdata     (w_entry_p0),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_rdata     (w_head)
    );

    assign out_data = w_head.data;
    assign out_src  = w_head.src;
    assign out_zero = w_head.zero;

endmodule

// File: tb/tb_alu_result_collector.sv
// Directed bench for alu_result_collector; macro-dependent checks follow ALU_COLLECTOR_SEL_CHECK_EN.
module tb_alu_result_collector;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] lanes;
    logic [7:0]   sel;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [2:0]   out_src;
    logic         out_zero;
    logic         sel_err;
    logic [7:0]   err_count;

    int n_assert;
    int n_fail;

    alu_result_collector dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .lanes     (lanes),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_zero  (out_zero),
        .sel_err   (sel_err),
        .err_count (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [7:0] s, input int idx, input logic [15:0] val);
        lanes = '0;
        lanes[idx*16 +: 16] = val;
        sel = s;
    endtask

    initial begin
        n_assert  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        lanes     = '0;
        sel       = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_src", 32'(out_src), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        chk("rst_sel_err", 32'(sel_err), 32'd0);
        chk("rst_err_count", 32'(err_count), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Single lane
        drive(8'b0000_0100, 2, 16'hA5A5);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'hA5A5);
        chk("single_src", 32'(out_src), 32'd2);
        chk("single_zero", 32'(out_zero), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_drained", 32'(out_valid), 32'd0);

        // Zero result, held while not consumed
        drive(8'b1000_0000, 7, 16'h0000);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("zero_valid", 32'(out_valid), 32'd1);
        chk("zero_data", 32'(out_data), 32'd0);
        chk("zero_src", 32'(out_src), 32'd7);
        chk("zero_flag", 32'(out_zero), 32'd1);
        tick();
        chk("zero_hold_valid", 32'(out_valid), 32'd1);
        chk("zero_hold_src", 32'(out_src), 32'd7);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("zero_drained", 32'(out_valid), 32'd0);

        // Fill and stall
        drive(8'b0000_0001, 0, 16'h1111);
        in_valid = 1'b1;
        tick();
        chk("fill1_in_ready", 32'(in_ready), 32'd1);
        drive(8'b0000_0010, 1, 16'h2222);
        tick();
        chk("fill2_in_ready", 32'(in_ready), 32'd0);
        drive(8'b0000_0100, 2, 16'h3333);
        tick();
        chk("stall_in_ready", 32'(in_ready), 32'd0);
        chk("stall_head_data", 32'(out_data), 32'h1111);
        chk("stall_head_src", 32'(out_src), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("pop1_data", 32'(out_data), 32'h2222);
        chk("pop1_src", 32'(out_src), 32'd1);
        chk("pop1_in_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("pop2_valid", 32'(out_valid), 32'd1);
        chk("pop2_data", 32'(out_data), 32'h3333);
        chk("pop2_src", 32'(out_src), 32'd2);
        tick();
        chk("fill_drained", 32'(out_valid), 32'd0);

        // Streaming with out_ready held high
        for (int k = 0; k < 10; k++) begin
            drive(8'(1 << (k % 8)), k % 8, 16'h1000 + 16'(k));
            in_valid = 1'b1;
            chk("stream_in_ready", 32'(in_ready), 32'd1);
            tick();
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_data", 32'(out_data), 32'h1000 + 32'(k));
            chk("stream_src", 32'(out_src), 32'(k % 8));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Multi-bit select
        lanes = '0;
        lanes[15:0]  = 16'h00F0;
        lanes[31:16] = 16'h0F00;
        sel = 8'b0000_0011;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
`ifdef ALU_COLLECTOR_SEL_CHECK_EN
        chk("err_no_push", 32'(out_valid), 32'd0);
        chk("err_pulse", 32'(sel_err), 32'd1);
        chk("err_count1", 32'(err_count), 32'd1);
        tick();
        chk("err_pulse_end", 32'(sel_err), 32'd0);
        chk("err_count_hold", 32'(err_count), 32'd1);
        in_valid = 1'b1;
        repeat (299) tick();
        in_valid = 1'b0;
        tick();
        chk("err_count_sat", 32'(err_count), 32'd255);
        chk("err_sat_no_push", 32'(out_valid), 32'd0);
`else
        chk("multi_valid", 32'(out_valid), 32'd1);
        chk("multi_data", 32'(out_data), 32'h0FF0);
        chk("multi_src", 32'(out_src), 32'd0);
        chk("multi_zero", 32'(out_zero), 32'd0);
        chk("multi_sel_err", 32'(sel_err), 32'd0);
        chk("multi_err_count", 32'(err_count), 32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("multi_drained", 32'(out_valid), 32'd0);
`endif

        // Reset while full, with a competing push
        drive(8'b0000_0001, 0, 16'hAAAA);
        in_valid = 1'b1;
        tick();
        drive(8'b0000_0010, 1, 16'hBBBB);
        tick();
        chk("prerst_in_ready", 32'(in_ready), 32'd0);
        chk("prerst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        out_ready = 1'b1;
        drive(8'b0000_0100, 2, 16'hCCCC);
        tick();
        rst_n = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_data", 32'(out_data), 32'd0);
        out_ready = 1'b1;
        tick();
        chk("midrst_no_stale", 32'(out_valid), 32'd0);
        out_ready = 1'b0;
        drive(8'b0000_1000, 3, 16'hDDDD);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("postrst_data", 32'(out_data), 32'hDDDD);
        chk("postrst_src", 32'(out_src), 32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_collector.md
# alu_result_collector

Receiving end of the ALU's AND-gated result lanes. Each functional unit drives a 16-bit lane that is gated by its select bit. This block captures one transfer per handshake and OR-combines the lanes into a single word. It tags the word with the source index and zero flag and buffers it in a 2-entry FIFO, which feeds the writeback stage through a valid/ready output.

## Interface
- `WIDTH`, 16: result word width.
- `N_SRC`, 8: number of gated result lanes / select bits.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `rst_n`  in  1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1: lanes and select are valid this cycle.
- `in_ready`  out  1: collector can accept; equals `count != 2`, driven from registered state only.
- `lanes`  in  N_SRC*WIDTH: lane i occupies bits [i*WIDTH +: WIDTH]; already AND-gated by its select bit upstream.
- `sel`  in  N_SRC: per-lane select bits as applied to the gates.
- `out_valid`  out  1: FIFO head valid.
- `out_ready`  in  1: writeback consumes head.
- `out_data`  out  WIDTH: head result word.
- `out_src`  out  $clog2(N_SRC): head source index.
- `out_zero`  out  1: head word is all zeros.
- `sel_err`  out  1: one-cycle pulse on a rejected transfer (macro only).
- `err_count`  out  8: saturating rejected-transfer count (macro only).

## Operation
- Accept occurs when `in_valid && in_ready`.
- Captured word is the bitwise OR of all N_SRC lanes. No per-lane masking is done here.
- `out_src` is the index of the lowest set `sel` bit, or 0 when `sel == 0`.
- `out_zero` is `~|word`, computed at capture.
- FIFO holds 2 entries `{data, src, zero}` with a write pointer, a read pointer (1-bit each, wrap 1→0) and a 2-bit `count`.
- Pop occurs when `out_valid && out_ready`.
- Count update:
  - push only: count+1
  - pop only: count−1
  - push and pop: count unchanged
- At count==2, `in_ready` is 0, so no push is possible in the same cycle as a pop. Ready reasserts the cycle after the pop.
- At count==0, `out_valid` is 0. An `out_ready` assertion is ignored.
- Outputs `out_data`/`out_src`/`out_zero` show the head entry and are stable while `out_valid && !out_ready`.
- Reset values: count 0, both pointers 0, `out_valid` 0, `out_data` 0, `out_src` 0, `out_zero` 0, `sel_err` 0, `err_count` 0.
- Reset has priority over any same-cycle push or pop. In-flight FIFO contents are discarded.
- After reset release, `in_ready` reads 1.

## Timing
- Accept-to-`out_valid` latency is 1 cycle when the FIFO is empty; no bypass path.
- Throughput is 1 transfer per cycle with `out_ready` held high.
- Back-to-back accepts with `out_ready` low fill both entries. `in_ready` drops the cycle after the second accept.
- `sel_err` asserts the cycle after the offending accept, for exactly one cycle.
- `err_count` increments in the same cycle as `sel_err` and saturates at 255.

## Configuration
- Controlled by macro `ALU_COLLECTOR_SEL_CHECK_EN`.
- Defined:
  - An accepted transfer whose `sel` is not exactly one-hot (zero or multiple bits) is consumed (handshake completes) but not pushed.
  - It produces the `sel_err` pulse and the `err_count` increment.
- Undefined:
  - Every accepted transfer is pushed using the src rule above.
  - `sel_err` is tied 0 and `err_count` is tied 0.
  - No check logic is synthesized.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_WORD_W` = 16
  - `ALU_N_SRC` = 8
  - `ALU_SRC_W` = $clog2(ALU_N_SRC)
  - typedef `alu_result_t` {data, src, zero}
- One sub-module, `alu_result_fifo2`: the 2-entry FIFO with its pointers, count, and valid/ready logic, storing `alu_result_t`.
- OR-combine, priority encode and one-hot check stay in the top.

## Test plan
- Single lane: `sel`=8'b0000_0100, lane2=16'hA5A5, other lanes 0 → one cycle later `out_valid`=1, `out_data`=16'hA5A5, `out_src`=2, `out_zero`=0.
- Fill/stall: three consecutive `in_valid` with `out_ready`=0 → first two accepted, `in_ready`=0 on the third. Then `out_ready`=1 drains both entries in order, and the third is accepted the cycle after the first pop.
- Streaming: 10 transfers with `out_ready`=1 on every cycle → 10 outputs on consecutive cycles, `in_ready` never drops, data in order.
- Zero result: `sel`=8'b1000_0000, lane7=0 → `out_data`=0, `out_src`=7, `out_zero`=1.
- With macro: `sel`=8'b0000_0011 → handshake completes, no push, `sel_err` pulses for 1 cycle, `err_count`=1. After 300 such transfers, `err_count`=255. Without macro, the same `sel` with lane0=16'h00F0 and lane1=16'h0F00 pushes `out_data`=16'h0FF0, `out_src`=0.
- Reset mid-operation: FIFO holds 2 entries, then `rst_n`=0 for one cycle → `out_valid`=0, `in_ready`=1 next cycle, and old entries never reappear.
